// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: ALU opcodes, operand-source
// select encodings and the hardwired zero register number.
package cpu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_NOR    = 5'd5;
  localparam logic [4:0] ALU_SLL    = 5'd6;
  localparam logic [4:0] ALU_SRL    = 5'd7;   // SRA when combined with ALU_SIGNED
  localparam logic [4:0] ALU_SLT    = 5'd8;   // SLTS when combined with ALU_SIGNED
  localparam logic [4:0] ALU_EQ     = 5'd9;
  localparam logic [4:0] ALU_NE     = 5'd10;
  localparam logic [4:0] ALU_LEZ    = 5'd11;
  localparam logic [4:0] ALU_GTZ    = 5'd12;
  localparam logic [4:0] ALU_LTZ    = 5'd13;
  localparam logic [4:0] ALU_SIGNED = 5'h10;

  localparam logic SRC1_RS    = 1'b0;
  localparam logic SRC1_SHAMT = 1'b1;
  localparam logic SRC2_RT    = 1'b0;
  localparam logic SRC2_IMM   = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_mux.sv
// Three-way priority operand select: EX/MEM result first, then MEM/WB
// writeback data, then the value latched at ID/EX capture. Register 0
// is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]  latched,
  input  logic               exm_reg_write,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_reg_write,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0]  mwb_data,
  output logic [DATA_W-1:0]  fwd
);

  // Youngest producer wins; fall back to the latched register value.
  always_comb begin
    fwd = latched;
    if (exm_reg_write && (exm_rd != RADDR_W'(REG_ZERO)) && (exm_rd == src_addr))
      fwd = exm_result;
    else if (mwb_reg_write && (mwb_rd != RADDR_W'(REG_ZERO)) && (mwb_rd == src_addr))
      fwd = mwb_data;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand preparation: capture-time MEM/WB
// bypass, EX-time forwarding, load-use stall, flush bubbles and
// saturating stall/flush event counters.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic               id_src1_sel,
  input  logic               id_src2_sel,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               exm_reg_write,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_reg_write,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0]  mwb_data,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [RADDR_W-1:0] rs_q, rt_q;
  logic [DATA_W-1:0]  rs_val_q, rt_val_q, imm_q;
  logic [4:0]         shamt_q;
  logic               src1_sel_q, src2_sel_q;
  logic               reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic               bubble;
  logic [DATA_W-1:0]  rs_cap, rt_cap, fwd_rs, fwd_rt;

  // Load-use hazard against the instruction now in EX; a flush overrides it.
  always_comb begin
    stall = id_valid && ex_valid && mem_read_q && (ex_rd != RADDR_W'(REG_ZERO)) &&
            ((id_uses_rs && (id_rs_addr == ex_rd)) || (id_uses_rt && (id_rt_addr == ex_rd))) &&
            !flush;
    bubble = stall || flush || !id_valid;
  end

  // Bypass the register file with the value being written back this cycle.
  always_comb begin
    rs_cap = id_rs_data;
    rt_cap = id_rt_data;
    if (mwb_reg_write && (mwb_rd != RADDR_W'(REG_ZERO)) && (mwb_rd == id_rs_addr))
      rs_cap = mwb_data;
    if (mwb_reg_write && (mwb_rd != RADDR_W'(REG_ZERO)) && (mwb_rd == id_rt_addr))
      rt_cap = mwb_data;
  end

  // ID/EX pipeline register; a bubble clears valid and every control bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      alu_op       <= ALUOP_W'(ALU_ADD);
      rs_q         <= '0;
      rt_q         <= '0;
      ex_rd        <= '0;
      rs_val_q     <= '0;
      rt_val_q     <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      src1_sel_q   <= SRC1_RS;
      src2_sel_q   <= SRC2_RT;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      ex_valid     <= !bubble;
      alu_op       <= id_alu_op;
      rs_q         <= id_rs_addr;
      rt_q         <= id_rt_addr;
      ex_rd        <= id_rd_addr;
      rs_val_q     <= rs_cap;
      rt_val_q     <= rt_cap;
      imm_q        <= id_imm;
      shamt_q      <= id_shamt;
      src1_sel_q   <= id_src1_sel;
      src2_sel_q   <= id_src2_sel;
      reg_write_q  <= !bubble && id_reg_write;
      mem_read_q   <= !bubble && id_mem_read;
      mem_write_q  <= !bubble && id_mem_write;
      mem_to_reg_q <= !bubble && id_mem_to_reg;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && id_valid && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
    .src_addr(rs_q), .latched(rs_val_q),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .fwd(fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
    .src_addr(rt_q), .latched(rt_val_q),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .fwd(fwd_rt)
  );

  // Operand selection and control gating toward the ALU and EX/MEM.
  always_comb begin
    alu_in1       = (src1_sel_q == SRC1_SHAMT) ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    alu_in2       = (src2_sel_q == SRC2_IMM) ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    ex_reg_write  = ex_valid && reg_write_q;
    ex_mem_read   = ex_valid && mem_read_q;
    ex_mem_write  = ex_valid && mem_write_q;
    ex_mem_to_reg = ex_valid && mem_to_reg_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus a
// randomized run against a transaction-level reference of the stage.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_alu_op;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic        id_src1_sel, id_src2_sel, id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        flush;
  logic        stall, ex_valid;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // Reference: the instruction currently sitting in EX, plus counters.
  logic        m_valid;
  logic [4:0]  m_op, m_rs, m_rt, m_rd, m_sh;
  logic [31:0] m_rsv, m_rtv, m_imm;
  logic        m_s1, m_s2, m_rw, m_mr, m_mw, m_mtr;
  int          m_scnt, m_fcnt;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Value of a source register as seen in EX, given the producers downstream.
  function automatic logic [31:0] ref_fwd(logic [4:0] a, logic [31:0] v);
    if (exm_reg_write && exm_rd != 0 && exm_rd == a) return exm_result;
    if (mwb_reg_write && mwb_rd != 0 && mwb_rd == a) return mwb_data;
    return v;
  endfunction

  function automatic logic ref_stall();
    logic dep;
    dep = (id_uses_rs && id_rs_addr == m_rd) || (id_uses_rt && id_rt_addr == m_rd);
    return id_valid && !flush && m_valid && m_mr && m_rd != 0 && dep;
  endfunction

  function automatic logic [31:0] ref_in1();
    return m_s1 ? {27'd0, m_sh} : ref_fwd(m_rs, m_rsv);
  endfunction

  function automatic logic [31:0] ref_in2();
    return m_s2 ? m_imm : ref_fwd(m_rt, m_rtv);
  endfunction

  task automatic model_update();
    logic kill;
    if (reset) begin
      {m_valid, m_rw, m_mr, m_mw, m_mtr} = '0;
      m_op = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      kill = ref_stall() || flush || !id_valid;
      if (ref_stall()) m_scnt = (m_scnt == 65535) ? 65535 : m_scnt + 1;
      if (flush && id_valid) m_fcnt = (m_fcnt == 65535) ? 65535 : m_fcnt + 1;
      m_valid = !kill;
      m_rw = !kill && id_reg_write; m_mr = !kill && id_mem_read;
      m_mw = !kill && id_mem_write; m_mtr = !kill && id_mem_to_reg;
      m_op = id_alu_op; m_rs = id_rs_addr; m_rt = id_rt_addr; m_rd = id_rd_addr;
      m_imm = id_imm; m_sh = id_shamt; m_s1 = id_src1_sel; m_s2 = id_src2_sel;
      m_rsv = (mwb_reg_write && mwb_rd != 0 && mwb_rd == id_rs_addr) ? mwb_data : id_rs_data;
      m_rtv = (mwb_reg_write && mwb_rd != 0 && mwb_rd == id_rt_addr) ? mwb_data : id_rt_data;
    end
  endtask

  // Advance one clock: update the reference with the inputs at the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_alu_op = ALU_ADD; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_src1_sel = SRC1_RS; id_src2_sel = SRC2_RT; id_uses_rs = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0; flush = 0;
  endtask

  // Put "lw $5,0($0)" in ID.
  task automatic issue_lw5();
    clear_inputs();
    id_valid = 1; id_alu_op = ALU_ADD; id_rs_addr = 0; id_rd_addr = 5;
    id_src2_sel = SRC2_IMM; id_uses_rs = 1;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  // Put "addu $6,$5,$5" in ID.
  task automatic issue_dep5();
    clear_inputs();
    id_valid = 1; id_alu_op = ALU_ADD; id_rs_addr = 5; id_rt_addr = 5; id_rd_addr = 6;
    id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1;
    id_rs_data = 32'hDEAD_0001; id_rt_data = 32'hDEAD_0002;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall});
    end
    checks++;
    if (alu_op !== 5'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_vals: alu_op=%0d stall_cnt=%0d flush_cnt=%0d required 0/0/0",
               alu_op, stall_cnt, flush_cnt);
    end
    reset = 0;
  endtask

  task automatic test_exm_forward();
    clear_inputs();
    id_valid = 1; id_alu_op = ALU_ADD; id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 3;
    id_rs_data = 5; id_rt_data = 2; id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_alu_op = ALU_SUB; id_rs_addr = 3; id_rt_addr = 1; id_rd_addr = 4;
    id_rs_data = 0; id_rt_data = 5; id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1;
    #1;
    checks++;
    if (ex_valid !== 1'b1 || alu_in1 !== 32'd5 || alu_in2 !== 32'd2 || ex_rd !== 5'd3) begin
      failures++;
      $display("FAIL add_in_ex: valid=%b in1=%h in2=%h rd=%0d required 1/5/2/3",
               ex_valid, alu_in1, alu_in2, ex_rd);
    end
    tick();
    clear_inputs();
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h0000_0007;
    #1;
    checks++;
    if (alu_in1 !== 32'h7 || alu_in2 !== 32'h5 || alu_op !== ALU_SUB || stall !== 1'b0) begin
      failures++;
      $display("FAIL exm_forward: in1=%h in2=%h op=%0d stall=%b required 7/5/1/0",
               alu_in1, alu_in2, alu_op, stall);
    end
  endtask

  // Continues with sub $4,$3,$1 still in EX.
  task automatic test_priority();
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'h22;
    #1;
    checks++;
    if (alu_in1 !== 32'h11) begin
      failures++;
      $display("FAIL fwd_priority: in1=%h required 00000011", alu_in1);
    end
    exm_reg_write = 0;
    #1;
    checks++;
    if (alu_in1 !== 32'h22) begin
      failures++;
      $display("FAIL mwb_forward: in1=%h required 00000022", alu_in1);
    end
  endtask

  task automatic test_load_use();
    issue_lw5();
    tick();
    issue_dep5();
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall: stall=%b required 1", stall);
    end
    tick();
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_bubble: valid=%b rw=%b stall=%b stall_cnt=%0d required 0/0/0/1",
               ex_valid, ex_reg_write, stall, stall_cnt);
    end
    exm_reg_write = 1; exm_rd = 5; exm_result = 32'h0000_0100;
    tick();
    clear_inputs();
    mwb_reg_write = 1; mwb_rd = 5; mwb_data = 32'hCAFE_F00D;
    #1;
    checks++;
    if (ex_valid !== 1'b1 || alu_in1 !== 32'hCAFE_F00D || alu_in2 !== 32'hCAFE_F00D ||
        stall_cnt !== 16'd1 || ex_rd !== 5'd6) begin
      failures++;
      $display("FAIL load_use_fwd: valid=%b in1=%h in2=%h stall_cnt=%0d rd=%0d required 1/cafef00d/cafef00d/1/6",
               ex_valid, alu_in1, alu_in2, stall_cnt, ex_rd);
    end
  endtask

  task automatic test_shift_and_zero();
    clear_inputs();
    id_valid = 1; id_alu_op = ALU_SLL; id_rt_addr = 7; id_rd_addr = 2; id_rt_data = 32'h1;
    id_shamt = 4; id_src1_sel = SRC1_SHAMT; id_uses_rt = 1; id_reg_write = 1;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (alu_in1 !== 32'd4 || alu_in2 !== 32'h1 || alu_op !== 5'd6 || ex_reg_write !== 1'b1) begin
      failures++;
      $display("FAIL sll_operands: in1=%h in2=%h op=%0d rw=%b required 4/1/6/1",
               alu_in1, alu_in2, alu_op, ex_reg_write);
    end
    id_valid = 1; id_alu_op = ALU_OR; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 8;
    id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1;
    mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFFFF_FFFF;
    mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || ex_store_data !== 32'd0) begin
      failures++;
      $display("FAIL reg_zero: in1=%h in2=%h store=%h required 0/0/0",
               alu_in1, alu_in2, ex_store_data);
    end
  endtask

  task automatic test_idle();
    int exp_s, exp_f;
    issue_lw5();
    tick();
    issue_dep5();
    id_valid = 0;
    exp_s = m_scnt; exp_f = m_fcnt;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_stall: stall=%b required 0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'(exp_s) || flush_cnt !== 16'(exp_f)) begin
      failures++;
      $display("FAIL idle_bubble: valid=%b stall_cnt=%0d flush_cnt=%0d required 0/%0d/%0d",
               ex_valid, stall_cnt, flush_cnt, exp_s, exp_f);
    end
  endtask

  task automatic test_flush_stall();
    int exp_s, exp_f;
    issue_lw5();
    tick();
    issue_dep5();
    flush = 1;
    exp_s = m_scnt; exp_f = m_fcnt + 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_masks_stall: stall=%b required 0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || flush_cnt !== 16'(exp_f) ||
        stall_cnt !== 16'(exp_s)) begin
      failures++;
      $display("FAIL flush_bubble: valid=%b rw=%b flush_cnt=%0d stall_cnt=%0d required 0/0/%0d/%0d",
               ex_valid, ex_reg_write, flush_cnt, stall_cnt, exp_f, exp_s);
    end
  endtask

  task automatic test_flush_saturate();
    clear_inputs();
    id_valid = 1; flush = 1; id_reg_write = 1; id_rd_addr = 9;
    for (int i = 0; i < 65536; i++) tick();
    checks++;
    if (flush_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL flush_saturate: flush_cnt=%h required ffff", flush_cnt);
    end
    tick();
    checks++;
    if (flush_cnt !== 16'hFFFF || ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_hold: flush_cnt=%h valid=%b required ffff/0", flush_cnt, ex_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    issue_lw5();
    tick();
    issue_dep5();
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stall: stall=%b required 1", stall);
    end
    reset = 1;
    tick();
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall} !== 6'b0 ||
        stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_stall: ctrl=%b stall_cnt=%0d flush_cnt=%0d required 000000/0/0",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall},
               stall_cnt, flush_cnt);
    end
    reset = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      id_valid      = ($urandom_range(0, 9) != 0);
      id_alu_op     = 5'($urandom_range(0, 31));
      id_rs_addr    = 5'($urandom_range(0, 3));
      id_rt_addr    = 5'($urandom_range(0, 3));
      id_rd_addr    = 5'($urandom_range(0, 3));
      id_rs_data    = $urandom;
      id_rt_data    = $urandom;
      id_imm        = $urandom;
      id_shamt      = 5'($urandom);
      id_src1_sel   = ($urandom_range(0, 3) == 0);
      id_src2_sel   = ($urandom_range(0, 2) == 0);
      id_uses_rs    = 1'($urandom);
      id_uses_rt    = 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      id_mem_write  = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      exm_reg_write = 1'($urandom);
      exm_rd        = 5'($urandom_range(0, 3));
      exm_result    = $urandom;
      mwb_reg_write = 1'($urandom);
      mwb_rd        = 5'($urandom_range(0, 3));
      mwb_data      = $urandom;
      flush         = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (stall !== ref_stall() || ex_valid !== m_valid ||
          {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== {m_rw, m_mr, m_mw, m_mtr} ||
          stall_cnt !== 16'(m_scnt) || flush_cnt !== 16'(m_fcnt)) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: stall=%b valid=%b ctrl=%b cnt=%0d/%0d required %b/%b/%b/%0d/%0d",
                 n, stall, ex_valid, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                 stall_cnt, flush_cnt, ref_stall(), m_valid, {m_rw, m_mr, m_mw, m_mtr},
                 m_scnt, m_fcnt);
      end
      if (m_valid) begin
        checks++;
        if (alu_op !== m_op || alu_in1 !== ref_in1() || alu_in2 !== ref_in2() ||
            ex_store_data !== ref_fwd(m_rt, m_rtv) || ex_rd !== m_rd) begin
          failures++;
          $display("FAIL rand_data[%0d]: op=%0d in1=%h in2=%h st=%h rd=%0d required %0d/%h/%h/%h/%0d",
                   n, alu_op, alu_in1, alu_in2, ex_store_data, ex_rd,
                   m_op, ref_in1(), ref_in2(), ref_fwd(m_rt, m_rtv), m_rd);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_exm_forward();
    test_priority();
    test_load_use();
    test_shift_and_zero();
    test_idle();
    test_flush_stall();
    test_flush_saturate();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-preparation logic for the pipelined CPU.
- Latches decoded instructions and resolves data hazards by forwarding from EX/MEM and MEM/WB; detects load-use hazards and inserts bubbles; handles branch/jump flush.
- Drives ALUOp/In1/In2 of the ALU directly and forwards control and store data down to EX/MEM.

Parameters:
DATA_W, 32, datapath width
RADDR_W, 5, register address width
ALUOP_W, 5, ALU opcode width (bit 4 = signed/arith modifier)
CNT_W, 16, width of stall/flush event counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_alu_op  in  ALUOP_W  decoded ALU opcode
id_rs_addr / id_rt_addr / id_rd_addr  in  RADDR_W  source/dest register numbers (rd = final write address)
id_rs_data / id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  extended immediate
id_shamt  in  5  shift amount
id_src1_sel  in  1  0 = rs, 1 = shamt (zero-extended)
id_src2_sel  in  1  0 = rt, 1 = imm
id_uses_rs / id_uses_rt  in  1  operand actually read (for hazard check)
id_reg_write / id_mem_read / id_mem_write / id_mem_to_reg  in  1  control
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  RADDR_W  EX/MEM write address
exm_result  in  DATA_W  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB writes a register
mwb_rd  in  RADDR_W  MEM/WB write address
mwb_data  in  DATA_W  MEM/WB writeback data
flush  in  1  kill the instruction in ID (taken branch/jump)
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
alu_op  out  ALUOP_W  to ALU
alu_in1 / alu_in2  out  DATA_W  to ALU
ex_store_data  out  DATA_W  forwarded rt for sw
ex_rd  out  RADDR_W  write address
ex_reg_write / ex_mem_read / ex_mem_write / ex_mem_to_reg  out  1  control, all gated by ex_valid
stall_cnt / flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: all registered state 0; ex_valid = 0; all control outputs 0; alu_op = 0 (add); counters = 0; stall = 0.
- Register capture every rising clk edge. Latency is one cycle from ID to the EX outputs.
- Load-use hazard is combinational: `stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs_addr == ex_rd) | (id_uses_rt & id_rt_addr == ex_rd))`, masked to 0 when flush = 1.
- Bubble: if stall or flush, the next EX state has ex_valid = 0 and all control bits = 0. Data registers may take any value; verification compares them only when ex_valid = 1.
- Flush with stall in the same cycle: flush wins, stall = 0, bubble inserted, flush_cnt increments, stall_cnt does not.
- Capture-time bypass: if mwb_reg_write and mwb_rd != 0 and mwb_rd == id_rs_addr, capture mwb_data instead of id_rs_data. The same rule applies to rt. This covers the instruction three ahead.
- EX-time forwarding (combinational on registered rs/rt) for each source:
  - EX/MEM match (exm_reg_write, exm_rd != 0, equal address) selects exm_result.
  - Otherwise a MEM/WB match selects mwb_data.
  - Otherwise the latched value is used.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand select:
  - alu_in1 = src1_sel ? {27'b0, shamt} : fwd_rs.
  - alu_in2 = src2_sel ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
- Counters saturate at all-ones with no wrap. stall_cnt increments on each cycle with stall = 1; flush_cnt increments on each flush cycle where id_valid = 1.
- Reset asserted mid-stall clears ex_valid and counters; stall deasserts the same cycle because it is gated by ex_valid.
- id_valid = 0 produces a bubble, with no stall and no counting.

Decomposition:
- Shared package cpu_pkg:
  - ALU opcode constants: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLL 6, SRL/SRA 7, SLT/SLTS 8, EQ 9, NE 10, LEZ 11, GTZ 12, LTZ 13, plus the SIGNED bit 4.
  - Source-select encodings.
  - REG_ZERO constant.
- One sub-module, fwd_mux: a 3-way priority forwarding select, instantiated for rs and rt.

Test Plan:
- add $3,$1,$2 followed by sub $4,$3,$1: EX/MEM forward → alu_in1 = exm_result (e.g. 0x0000_0007), no stall.
- Same $3 written in both EX/MEM (0x11) and MEM/WB (0x22): alu_in1 = 0x11 (priority check).
- lw $5,0($0) followed by addu $6,$5,$5: stall = 1 for exactly one cycle, bubble (ex_valid = 0), stall_cnt = 1, then the add sees the forwarded MEM/WB data.
- sll $2,$7,4 with rt = 0x1: alu_in1 = 4, alu_in2 = 0x1, alu_op = 6. Writes to $0 with value 0xFFFF_FFFF are never forwarded (alu_in1 = 0).
- flush and a load-use hazard in the same cycle: stall = 0, ex_valid = 0 next cycle, flush_cnt +1; drive 2^CNT_W flushes → flush_cnt holds 0xFFFF.
- Assert reset during a stall: next cycle ex_valid = 0, all controls 0, counters 0, stall = 0.
